csr_file: RTL and testbench
===========================

Name: csr_file

Overview:
Machine-mode CSR responder for the single-issue RV64 core. It serves the execute unit's CSR access port: combinational read data is returned in the same cycle so the execute unit can form the read-modify-write value. The write commits exactly once per request under a req/ack handshake. It also owns the mcycle/minstret counters and the trap-entry and mret state updates.

Parameters:
HART_ID, 64'd0, value returned by mhartid.
MISA_VAL, 64'h8000_0000_0000_0100, read-only misa (MXL=2, I).

Ports:
clk  in  1  core clock
rst  in  1  asynchronous, active-low reset (0 = reset)
i_req  in  1  CSR request from execute unit, level, held until acked
o_ack  out  1  one-cycle acknowledge; write has committed
i_csr_addr  in  12  CSR address
i_csr_ren  in  1  read enable
i_csr_wen  in  1  write enable, qualified by i_req
i_csr_wdata  in  64  full new CSR value (RMW already applied by execute unit)
o_csr_rdata  out  64  combinational read data
i_instret_inc  in  1  one pulse per retired instruction
i_trap  in  1  trap entry pulse
i_trap_pc  in  64  faulting PC to mepc
i_trap_cause  in  64  mcause value
i_mret  in  1  mret pulse
o_trap_vec  out  64  {mtvec[63:2],2'b00}
o_mepc  out  64  current mepc, mret target

Behaviour:
- Reset (rst=0, async): o_ack=0; FSM=IDLE; mstatus=64'h1800 (MPP=11); mie, mtvec, mscratch, mepc, mcause, mcycle, minstret all 0.
- Implemented CSRs: mstatus 300, misa 301 (RO), mie 304, mtvec 305, mscratch 340, mepc 341, mcause 342, mip 344 (RO 0), mcycle B00, minstret B02, mhartid F14 (RO).
- Read: o_csr_rdata = selected CSR when i_csr_ren=1, else 0. Zero latency; returns the pre-write value in the cycle a write commits. Unimplemented addresses read 0; writes to them and to RO CSRs are ignored but still acked.
- Write masking: mstatus writable bits are MIE[3], MPIE[7] and FS[14:13]. MPP is fixed at 11. SD[63] = (FS==11). mtvec[1:0] is forced 00 (direct mode only). mepc[1:0] is forced 00. Other CSRs are fully writable.
- Handshake FSM, states IDLE, ACK, HOLD:
  - IDLE & i_req: commit the write at this edge if i_csr_wen; go to ACK.
  - ACK: o_ack=1 for exactly this cycle. If i_req=1, go to HOLD; else go to IDLE.
  - HOLD: no writes, o_ack=0. Return to IDLE when i_req=0.
  - Each request therefore commits at most once, even though the requester holds req and wen for several cycles.
  - o_ack is registered and asserts one cycle after i_req is first seen.
- mcycle: +1 every cycle out of reset, wrapping FFFF_FFFF_FFFF_FFFF to 0. A committed write in a cycle loads wdata with no increment that cycle.
- minstret: +1 on i_instret_inc, wrapping the same way. A write in the same cycle wins and the increment is lost.
- Trap (i_trap): mepc<=i_trap_pc & ~3; mcause<=i_trap_cause; MPIE<=MIE; MIE<=0; MPP stays 11.
- mret (i_mret): MIE<=MPIE; MPIE<=1.
- Priority: i_trap > i_mret > CSR write, applied only to the fields the higher-priority event touches; other fields still take the CSR write. Simultaneous i_trap and i_mret: the trap wins and mret is ignored.
- Reset asserted mid-handshake: FSM returns to IDLE and no ack is issued. A requester still holding i_req after reset release is served as a new request.

Decomposition:
- Shared package csr_defs: CSR address constants, mstatus bit positions, mstatus write mask, reset constants.
- Sub-module csr_counter64 (inputs clk, rst, inc, wen, wdata; output cnt): 64-bit counter with write-over-increment priority. It is instantiated twice, once for mcycle and once for minstret.

Test Plan:
- Reset, then hold i_req=0 for 10 cycles, then read B00 -> rdata=10. misa read -> 8000_0000_0000_0100. mstatus -> 1800.
- i_req=1, wen=1, addr 340, wdata DEAD_BEEF, held 4 cycles -> single ack one cycle after req; mscratch=DEAD_BEEF; FSM in HOLD until req drops; a second read returns DEAD_BEEF.
- Write mcycle=FFFF_FFFF_FFFF_FFFE -> reads …FFFF after one cycle, 0 after two cycles. Write minstret=5 with i_instret_inc=1 in the same cycle -> minstret=5.
- Write mstatus=FFFF_FFFF_FFFF_FFFF -> reads 8000_0000_0000_7888. Write mtvec=8000_0003 -> o_trap_vec=8000_0000.
- MIE=1, then i_trap with pc=8000_0102 and cause=B -> mepc=8000_0100, mcause=B, MIE=0, MPIE=1. Then i_mret -> MIE=1, MPIE=1, o_mepc=8000_0100.
- Drop rst while in ACK -> o_ack=0 immediately. After release with i_req held high, a fresh ack arrives one cycle later and the write commits once.

Source files
------------

// File: rtl/csr_defs.sv
`default_nettype none
// ============================================================================
//  Module   : csr_defs (package)
//  Brief    : Shared constants for the machine-mode CSR responder: CSR
//             addresses, mstatus field positions, write mask, reset values
//             and the handshake state type.
//  Revision : 1.0 - initial release
// ============================================================================
package csr_defs;

    // Implemented CSR addresses
    localparam logic [11:0] C_CSR_MSTATUS  = 12'h300;
    localparam logic [11:0] C_CSR_MISA     = 12'h301;
    localparam logic [11:0] C_CSR_MIE      = 12'h304;
    localparam logic [11:0] C_CSR_MTVEC    = 12'h305;
    localparam logic [11:0] C_CSR_MSCRATCH = 12'h340;
    localparam logic [11:0] C_CSR_MEPC     = 12'h341;
    localparam logic [11:0] C_CSR_MCAUSE   = 12'h342;
    localparam logic [11:0] C_CSR_MIP      = 12'h344;
    localparam logic [11:0] C_CSR_MCYCLE   = 12'hB00;
    localparam logic [11:0] C_CSR_MINSTRET = 12'hB02;
    localparam logic [11:0] C_CSR_MHARTID  = 12'hF14;

    // mstatus field positions
    localparam int C_MIE_BIT   = 3;
    localparam int C_MPIE_BIT  = 7;
    localparam int C_FS_LO_BIT = 13;
    localparam int C_FS_HI_BIT = 14;
    localparam int C_SD_BIT    = 63;

    // Only MIE, MPIE and FS take software writes; MPP is hardwired to 11
    localparam logic [63:0] C_MSTATUS_WMASK = 64'h0000_0000_0000_6088;
    localparam logic [63:0] C_MSTATUS_RST   = 64'h0000_0000_0000_1800;

    // Low two bits cleared on mtvec/mepc (direct mode, aligned targets)
    localparam logic [63:0] C_ALIGN4_MASK   = ~64'd3;

    // Request handshake states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACK  = 2'd1,
        ST_HOLD = 2'd2
    } hs_state_e;

    // Stored mstatus never holds SD; it is derived from FS on every read
    function automatic logic [63:0] mstatus_view(input logic [63:0] raw);
        logic [63:0] v;
        v           = raw;
        v[C_SD_BIT] = raw[C_FS_HI_BIT] & raw[C_FS_LO_BIT];
        return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/csr_file_if.sv
`default_nettype none
// ============================================================================
//  Module   : csr_file_if
//  Brief    : Execute-unit CSR access port: level request, one-cycle ack,
//             address/enables, write data and zero-latency read data.
//  Revision : 1.0 - initial release
// ============================================================================
interface csr_file_if;
    logic        i_req;
    logic        o_ack;
    logic [11:0] i_csr_addr;
    logic        i_csr_ren;
    logic        i_csr_wen;
    logic [63:0] i_csr_wdata;
    logic [63:0] o_csr_rdata;

    modport master (
        output i_req, i_csr_addr, i_csr_ren, i_csr_wen, i_csr_wdata,
        input  o_ack, o_csr_rdata
    );

    modport slave (
        input  i_req, i_csr_addr, i_csr_ren, i_csr_wen, i_csr_wdata,
        output o_ack, o_csr_rdata
    );
endinterface
`default_nettype wire

// File: rtl/csr_counter64.sv
`default_nettype none
// ============================================================================
//  Module   : csr_counter64
//  Brief    : 64-bit wrapping counter; a write in a cycle replaces that
//             cycle's increment.
//  Revision : 1.0 - initial release
// ============================================================================
module csr_counter64 (
    input  wire         clk,
    input  wire         rst,
    input  wire         inc,
    input  wire         wen,
    input  wire  [63:0] wdata,
    output logic [63:0] cnt
);

    logic [63:0] r_cnt_q;
    logic [63:0] w_cnt_d;

    // Next count: write beats increment, increment wraps naturally
    always_comb begin
        w_cnt_d = r_cnt_q;
        if (wen) begin
            w_cnt_d = wdata;
        end else if (inc) begin
            w_cnt_d = r_cnt_q + 64'd1;
        end
    end

    // Count register, cleared by the active-low asynchronous reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt_q <= '0;
        end else begin
            r_cnt_q <= w_cnt_d;
        end
    end

    assign cnt = r_cnt_q;

endmodule
`default_nettype wire

// File: rtl/csr_file.sv
`default_nettype none
// ============================================================================
//  Module   : csr_file
//  Brief    : Machine-mode CSR responder for the RV64 core. Zero-latency
//             reads, once-per-request writes under req/ack, mcycle/minstret
//             counters, trap entry and mret state updates.
//  Revision : 1.0 - initial release
// ============================================================================
module csr_file
    import csr_defs::*;
#(
    parameter logic [63:0] HART_ID  = 64'd0,
    parameter logic [63:0] MISA_VAL = 64'h8000_0000_0000_0100
) (
    input  wire         clk,
    input  wire         rst,
    csr_file_if.slave   bus,
    input  wire         i_instret_inc,
    input  wire         i_trap,
    input  wire  [63:0] i_trap_pc,
    input  wire  [63:0] i_trap_cause,
    input  wire         i_mret,
    output logic [63:0] o_trap_vec,
    output logic [63:0] o_mepc
);

    hs_state_e   r_state_q;
    logic        r_ack_q;

    logic [63:0] r_mstatus_q,  w_mstatus_d;
    logic [63:0] r_mie_q,      w_mie_d;
    logic [63:0] r_mtvec_q,    w_mtvec_d;
    logic [63:0] r_mscratch_q, w_mscratch_d;
    logic [63:0] r_mepc_q,     w_mepc_d;
    logic [63:0] r_mcause_q,   w_mcause_d;

    logic [63:0] w_mcycle;
    logic [63:0] w_minstret;
    logic [63:0] w_rdata;

    logic        w_commit;
    logic        w_wr_mcycle;
    logic        w_wr_minstret;

    // A write lands only on the edge where an idle responder first sees req,
    // so a requester holding req/wen for many cycles still commits once.
    assign w_commit      = (r_state_q == ST_IDLE) && bus.i_req && bus.i_csr_wen;
    assign w_wr_mcycle   = w_commit && (bus.i_csr_addr == C_CSR_MCYCLE);
    assign w_wr_minstret = w_commit && (bus.i_csr_addr == C_CSR_MINSTRET);

    // Handshake FSM with registered ack, high only in the ACK state
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state_q <= ST_IDLE;
            r_ack_q   <= 1'b0;
        end else begin
            r_ack_q <= 1'b0;
            case (r_state_q)
                ST_IDLE: begin
                    if (bus.i_req) begin
                        r_state_q <= ST_ACK;
                        r_ack_q   <= 1'b1;
                    end
                end
                ST_ACK: begin
                    r_state_q <= bus.i_req ? ST_HOLD : ST_IDLE;
                end
                ST_HOLD: begin
                    if (!bus.i_req) begin
                        r_state_q <= ST_IDLE;
                    end
                end
                default: begin
                    r_state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // CSR next state: software write first, then trap/mret override only
    // the fields they own so unrelated fields still take the write
    always_comb begin
        w_mstatus_d  = r_mstatus_q;
        w_mie_d      = r_mie_q;
        w_mtvec_d    = r_mtvec_q;
        w_mscratch_d = r_mscratch_q;
        w_mepc_d     = r_mepc_q;
        w_mcause_d   = r_mcause_q;

        if (w_commit) begin
            case (bus.i_csr_addr)
                C_CSR_MSTATUS:  w_mstatus_d  = (r_mstatus_q & ~C_MSTATUS_WMASK)
                                             | (bus.i_csr_wdata & C_MSTATUS_WMASK);
                C_CSR_MIE:      w_mie_d      = bus.i_csr_wdata;
                C_CSR_MTVEC:    w_mtvec_d    = bus.i_csr_wdata & C_ALIGN4_MASK;
                C_CSR_MSCRATCH: w_mscratch_d = bus.i_csr_wdata;
                C_CSR_MEPC:     w_mepc_d     = bus.i_csr_wdata & C_ALIGN4_MASK;
                C_CSR_MCAUSE:   w_mcause_d   = bus.i_csr_wdata;
                default:        ;
            endcase
        end

        if (i_trap) begin
            w_mepc_d                 = i_trap_pc & C_ALIGN4_MASK;
            w_mcause_d               = i_trap_cause;
            w_mstatus_d[C_MPIE_BIT]  = r_mstatus_q[C_MIE_BIT];
            w_mstatus_d[C_MIE_BIT]   = 1'b0;
        end else if (i_mret) begin
            w_mstatus_d[C_MIE_BIT]   = r_mstatus_q[C_MPIE_BIT];
            w_mstatus_d[C_MPIE_BIT]  = 1'b1;
        end
    end

    // CSR storage registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_mstatus_q  <= C_MSTATUS_RST;
            r_mie_q      <= '0;
            r_mtvec_q    <= '0;
            r_mscratch_q <= '0;
            r_mepc_q     <= '0;
            r_mcause_q   <= '0;
        end else begin
            r_mstatus_q  <= w_mstatus_d;
            r_mie_q      <= w_mie_d;
            r_mtvec_q    <= w_mtvec_d;
            r_mscratch_q <= w_mscratch_d;
            r_mepc_q     <= w_mepc_d;
            r_mcause_q   <= w_mcause_d;
        end
    end

    csr_counter64 u_mcycle (
        .clk   (clk),
        .rst   (rst),
        .inc   (1'b1),
        .wen   (w_wr_mcycle),
        .wdata (bus.i_csr_wdata),
        .cnt   (w_mcycle)
    );

    csr_counter64 u_minstret (
        .clk   (clk),
        .rst   (rst),
        .inc   (i_instret_inc),
        .wen   (w_wr_minstret),
        .wdata (bus.i_csr_wdata),
        .cnt   (w_minstret)
    );

    // Zero-latency read mux; shows the pre-write value in a commit cycle
    always_comb begin
        w_rdata = '0;
        if (bus.i_csr_ren) begin
            case (bus.i_csr_addr)
                C_CSR_MSTATUS:  w_rdata = mstatus_view(r_mstatus_q);
                C_CSR_MISA:     w_rdata = MISA_VAL;
                C_CSR_MIE:      w_rdata = r_mie_q;
                C_CSR_MTVEC:    w_rdata = r_mtvec_q;
                C_CSR_MSCRATCH: w_rdata = r_mscratch_q;
                C_CSR_MEPC:     w_rdata = r_mepc_q;
                C_CSR_MCAUSE:   w_rdata = r_mcause_q;
                C_CSR_MIP:      w_rdata = '0;
                C_CSR_MCYCLE:   w_rdata = w_mcycle;
                C_CSR_MINSTRET: w_rdata = w_minstret;
                C_CSR_MHARTID:  w_rdata = HART_ID;
                default:        w_rdata = '0;
            endcase
        end
    end

    assign bus.o_csr_rdata = w_rdata;
    assign bus.o_ack       = r_ack_q;
    assign o_trap_vec      = {r_mtvec_q[63:2], 2'b00};
    assign o_mepc          = r_mepc_q;

endmodule
`default_nettype wire

// File: tb/tb_csr_file.sv
`default_nettype none
// ============================================================================
//  Module   : tb_csr_file
//  Brief    : Self-checking bench for csr_file: directed vectors, a
//             behavioural CSR model compared every cycle, and literal checks.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_csr_file;

    logic        clk;
    logic        rst;
    logic        i_instret_inc;
    logic        i_trap;
    logic [63:0] i_trap_pc;
    logic [63:0] i_trap_cause;
    logic        i_mret;
    logic [63:0] o_trap_vec;
    logic [63:0] o_mepc;

    csr_file_if bus ();

    csr_file #(
        .HART_ID  (64'd0),
        .MISA_VAL (64'h8000_0000_0000_0100)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .bus           (bus),
        .i_instret_inc (i_instret_inc),
        .i_trap        (i_trap),
        .i_trap_pc     (i_trap_pc),
        .i_trap_cause  (i_trap_cause),
        .i_mret        (i_mret),
        .o_trap_vec    (o_trap_vec),
        .o_mepc        (o_mepc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;
    bit done  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [63:0] m_ie_csr, m_mtvec, m_mscratch, m_mepc, m_mcause, m_mcycle, m_minstret;
    bit          m_st_mie, m_st_mpie;
    logic [1:0]  m_fs;
    bit          m_ack;     // ack visible this cycle
    bit          m_busy;    // current request already served, waiting for req drop
    bit          m_commit, m_old_mie, m_old_mpie;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_ie_csr = 0; m_mtvec = 0; m_mscratch = 0; m_mepc = 0; m_mcause = 0;
            m_mcycle = 0; m_minstret = 0;
            m_st_mie = 0; m_st_mpie = 0; m_fs = 0;
            m_ack = 0; m_busy = 0;
        end else begin
            m_commit = 0;
            if (m_ack) begin
                m_ack  = 0;
                m_busy = bus.i_req;
            end else if (m_busy) begin
                m_busy = bus.i_req;
            end else if (bus.i_req) begin
                m_ack    = 1;
                m_commit = bus.i_csr_wen;
            end
            m_old_mie  = m_st_mie;
            m_old_mpie = m_st_mpie;
            m_mcycle   = m_mcycle + 1;
            if (i_instret_inc) m_minstret = m_minstret + 1;
            if (m_commit) begin
                case (bus.i_csr_addr)
                    12'h300: begin
                        m_st_mie  = bus.i_csr_wdata[3];
                        m_st_mpie = bus.i_csr_wdata[7];
                        m_fs      = bus.i_csr_wdata[14:13];
                    end
                    12'h304: m_ie_csr   = bus.i_csr_wdata;
                    12'h305: m_mtvec    = bus.i_csr_wdata & ~64'd3;
                    12'h340: m_mscratch = bus.i_csr_wdata;
                    12'h341: m_mepc     = bus.i_csr_wdata & ~64'd3;
                    12'h342: m_mcause   = bus.i_csr_wdata;
                    12'hB00: m_mcycle   = bus.i_csr_wdata;
                    12'hB02: m_minstret = bus.i_csr_wdata;
                    default: ;
                endcase
            end
            if (i_trap) begin
                m_mepc    = i_trap_pc & ~64'd3;
                m_mcause  = i_trap_cause;
                m_st_mpie = m_old_mie;
                m_st_mie  = 0;
            end else if (i_mret) begin
                m_st_mie  = m_old_mpie;
                m_st_mpie = 1;
            end
        end
    end

    function automatic logic [63:0] model_read(input logic [11:0] a, input logic en);
        logic [63:0] v;
        v = 64'd0;
        if (en) begin
            case (a)
                12'h300: v = ((m_fs == 2'b11) ? 64'h8000_0000_0000_0000 : 64'd0)
                           + 64'(m_fs) * 64'h2000 + 64'h1800
                           + (m_st_mpie ? 64'h80 : 64'd0) + (m_st_mie ? 64'h8 : 64'd0);
                12'h301: v = 64'h8000_0000_0000_0100;
                12'h304: v = m_ie_csr;
                12'h305: v = m_mtvec;
                12'h340: v = m_mscratch;
                12'h341: v = m_mepc;
                12'h342: v = m_mcause;
                12'hB00: v = m_mcycle;
                12'hB02: v = m_minstret;
                default: v = 64'd0;
            endcase
        end
        return v;
    endfunction

    // Per-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        if (!done) begin
            if (!rst) begin
                check("ack_in_reset", {63'd0, bus.o_ack}, 64'd0);
            end else begin
                check("ack", {63'd0, bus.o_ack}, {63'd0, m_ack});
                check("trap_vec", o_trap_vec, m_mtvec);
                check("mepc", o_mepc, m_mepc);
                check("rdata", bus.o_csr_rdata, model_read(bus.i_csr_addr, bus.i_csr_ren));
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [11:0] a, input logic [63:0] d);
        bus.i_req = 1; bus.i_csr_wen = 1; bus.i_csr_addr = a; bus.i_csr_wdata = d;
        tick();
        bus.i_req = 0; bus.i_csr_wen = 0;
        tick();
    endtask

    task automatic rd_check(input string n, input logic [11:0] a, input logic [63:0] e);
        tick();
        bus.i_csr_ren = 1; bus.i_csr_addr = a;
        #1;
        check(n, bus.o_csr_rdata, e);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 0;
        bus.i_req = 0; bus.i_csr_addr = 0; bus.i_csr_ren = 0; bus.i_csr_wen = 0; bus.i_csr_wdata = 0;
        i_instret_inc = 0; i_trap = 0; i_trap_pc = 0; i_trap_cause = 0; i_mret = 0;
        repeat (3) tick();
        check("reset_ack", {63'd0, bus.o_ack}, 64'd0);
        rst = 1;

        // mcycle counts every cycle out of reset
        bus.i_csr_ren = 1; bus.i_csr_addr = 12'hB00;
        #1;
        check("mcycle_at_release", bus.o_csr_rdata, 64'd0);
        repeat (10) tick();
        check("mcycle_10", bus.o_csr_rdata, 64'd10);
        rd_check("misa", 12'h301, 64'h8000_0000_0000_0100);
        rd_check("mstatus_reset", 12'h300, 64'h1800);
        rd_check("mhartid", 12'hF14, 64'd0);

        // held request commits once and acks once
        tick();
        bus.i_req = 1; bus.i_csr_wen = 1; bus.i_csr_addr = 12'h340; bus.i_csr_wdata = 64'hDEAD_BEEF;
        #1;
        check("ack_before_edge", {63'd0, bus.o_ack}, 64'd0);
        check("mscratch_prewrite", bus.o_csr_rdata, 64'd0);
        tick();
        check("ack_one_cycle_later", {63'd0, bus.o_ack}, 64'd1);
        check("mscratch_written", bus.o_csr_rdata, 64'hDEAD_BEEF);
        tick();
        check("ack_hold1", {63'd0, bus.o_ack}, 64'd0);
        bus.i_csr_wdata = 64'h1111;
        tick();
        check("no_recommit", bus.o_csr_rdata, 64'hDEAD_BEEF);
        tick();
        check("ack_hold3", {63'd0, bus.o_ack}, 64'd0);
        bus.i_req = 0; bus.i_csr_wen = 0;
        tick();
        rd_check("mscratch_reread", 12'h340, 64'hDEAD_BEEF);

        // mcycle wrap after write
        tick();
        bus.i_req = 1; bus.i_csr_wen = 1; bus.i_csr_addr = 12'hB00;
        bus.i_csr_wdata = 64'hFFFF_FFFF_FFFF_FFFE;
        tick();
        check("mcycle_loaded", bus.o_csr_rdata, 64'hFFFF_FFFF_FFFF_FFFE);
        bus.i_req = 0; bus.i_csr_wen = 0;
        tick();
        check("mcycle_max", bus.o_csr_rdata, 64'hFFFF_FFFF_FFFF_FFFF);
        tick();
        check("mcycle_wrap", bus.o_csr_rdata, 64'd0);

        // minstret write beats increment
        bus.i_req = 1; bus.i_csr_wen = 1; bus.i_csr_addr = 12'hB02; bus.i_csr_wdata = 64'd5;
        i_instret_inc = 1;
        tick();
        i_instret_inc = 0;
        check("minstret_write_wins", bus.o_csr_rdata, 64'd5);
        bus.i_req = 0; bus.i_csr_wen = 0;
        tick();
        i_instret_inc = 1;
        tick();
        i_instret_inc = 0;
        check("minstret_inc", bus.o_csr_rdata, 64'd6);

        // write masking
        do_write(12'h300, 64'hFFFF_FFFF_FFFF_FFFF);
        rd_check("mstatus_mask", 12'h300, 64'h8000_0000_0000_7888);
        do_write(12'h305, 64'h8000_0003);
        check("trap_vec_align", o_trap_vec, 64'h8000_0000);
        rd_check("mtvec_read", 12'h305, 64'h8000_0000);
        do_write(12'h341, 64'h1003);
        check("mepc_align", o_mepc, 64'h1000);
        do_write(12'h301, 64'd0);
        rd_check("misa_ro", 12'h301, 64'h8000_0000_0000_0100);
        do_write(12'h7C0, 64'h55);
        rd_check("unimpl_read", 12'h7C0, 64'd0);
        do_write(12'h304, 64'h888);
        rd_check("mie_rw", 12'h304, 64'h888);

        // trap entry and mret
        do_write(12'h300, 64'h8);
        rd_check("mstatus_mie", 12'h300, 64'h1808);
        i_trap = 1; i_trap_pc = 64'h8000_0102; i_trap_cause = 64'hB;
        tick();
        i_trap = 0;
        check("trap_mepc", o_mepc, 64'h8000_0100);
        rd_check("trap_mcause", 12'h342, 64'hB);
        rd_check("trap_mstatus", 12'h300, 64'h1880);
        i_mret = 1;
        tick();
        i_mret = 0;
        check("mret_mepc", o_mepc, 64'h8000_0100);
        rd_check("mret_mstatus", 12'h300, 64'h1888);

        // trap + mret + mstatus write in one cycle: trap owns MIE/MPIE, FS from write
        tick();
        bus.i_req = 1; bus.i_csr_wen = 1; bus.i_csr_addr = 12'h300; bus.i_csr_wdata = 64'h6000;
        i_trap = 1; i_mret = 1; i_trap_pc = 64'h8000_0204; i_trap_cause = 64'h8000_0000_0000_0007;
        tick();
        i_trap = 0; i_mret = 0;
        check("prio_mstatus", bus.o_csr_rdata, 64'h8000_0000_0000_7880);
        check("prio_mepc", o_mepc, 64'h8000_0204);
        bus.i_req = 0; bus.i_csr_wen = 0;
        tick();

        // reset during ACK, then held request served afresh
        bus.i_req = 1; bus.i_csr_wen = 1; bus.i_csr_addr = 12'h340; bus.i_csr_wdata = 64'h1234;
        tick();
        check("pre_reset_ack", {63'd0, bus.o_ack}, 64'd1);
        rst = 0;
        #1;
        check("reset_kills_ack", {63'd0, bus.o_ack}, 64'd0);
        check("reset_clears_mscratch", bus.o_csr_rdata, 64'd0);
        tick();
        bus.i_csr_wdata = 64'h5678;
        rst = 1;
        tick();
        check("fresh_ack", {63'd0, bus.o_ack}, 64'd1);
        check("fresh_write", bus.o_csr_rdata, 64'h5678);
        bus.i_csr_wdata = 64'h9999;
        tick();
        check("fresh_hold_ack", {63'd0, bus.o_ack}, 64'd0);
        tick();
        check("fresh_single_commit", bus.o_csr_rdata, 64'h5678);
        bus.i_req = 0; bus.i_csr_wen = 0;
        repeat (3) tick();

        done = 1;
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
